// File: rtl/fp_int_wb_queue.sv
`default_nettype none
//============================================================================
// Module   : fp_int_wb_queue
// Purpose  : In-order FIFO between the FPU integer-result producers
//            (FCLASS, FEQ/FLT/FLE, FCVT.W[U], FMV.X.W) and the integer
//            register file writeback port. It decouples the single-cycle
//            producers from writeback arbitration stalls.
// Ports    : clk, reset_n (sync, active-low), flush (sync discard)
//            in_valid/in_ready/in_data/in_rd/in_fflags  - producer side
//            out_valid/out_ready/out_data/out_rd/out_fflags - writeback side
//            count - number of stored entries
// Revision : 1.0 - initial release
//============================================================================
module fp_int_wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_data,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_fflags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_data,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_fflags,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    logic [XLEN-1:0]    r_data_mem  [DEPTH];
    logic [4:0]         r_rd_mem    [DEPTH];
    logic [4:0]         r_flags_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_store;
    logic w_pop;
    logic w_clear;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

    // Readiness depends on stored state only; a pop in the same cycle does
    // not free a slot for a push into a full queue.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;

    assign w_clear = !reset_n || flush;
    assign w_push  = in_valid && in_ready;
    // A write to x0 with no flags has no architectural effect, so the
    // handshake completes but nothing is stored.
    assign w_store = w_push && !((in_rd == 5'd0) && (in_fflags == 5'd0));
    assign w_pop   = out_valid && out_ready;

    // Head fields are gated so an empty queue presents all-zero outputs
    // regardless of stale storage.
    assign out_data   = w_empty ? '0   : r_data_mem[r_rd_ptr];
    assign out_rd     = w_empty ? 5'd0 : r_rd_mem[r_rd_ptr];
    assign out_fflags = w_empty ? 5'd0 : r_flags_mem[r_rd_ptr];
    assign count      = r_count;

    // Storage needs no reset; visibility is controlled by r_count.
    always_ff @(posedge clk) begin
        if (!w_clear && w_store) begin
            r_data_mem[r_wr_ptr]  <= in_data;
            r_rd_mem[r_wr_ptr]    <= in_rd;
            r_flags_mem[r_wr_ptr] <= in_fflags;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_int_wb_queue.sv
`default_nettype none
//============================================================================
// Module   : tb_fp_int_wb_queue
// Purpose  : Scoreboard bench for fp_int_wb_queue. Directed scenarios are
//            followed by randomized traffic; a monitor compares the DUT
//            against a queue-based reference model every cycle.
// Revision : 1.0 - initial release
//============================================================================
module tb_fp_int_wb_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic [4:0]      ff;
    } entry_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data;
    logic [4:0]      in_rd;
    logic [4:0]      in_fflags;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [4:0]      out_rd;
    logic [4:0]      out_fflags;
    logic [CW-1:0]   count;

    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;
    entry_t exp_q[$];
    int     sz;
    entry_t e;

    fp_int_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_rd      (in_rd),
        .in_fflags  (in_fflags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_fflags (out_fflags),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: compare outputs against the reference queue,
    // then advance the model by what the coming rising edge will do.
    always @(negedge clk) begin
        if (mon_en) begin
            sz = exp_q.size();
            check("count", 64'(count), 64'(sz));
            check("in_ready", 64'(in_ready), 64'(sz < DEPTH));
            check("out_valid", 64'(out_valid), 64'(sz != 0));
            if (sz == 0) begin
                check("empty_out_data", 64'(out_data), 64'd0);
                check("empty_out_rd", 64'(out_rd), 64'd0);
                check("empty_out_fflags", 64'(out_fflags), 64'd0);
            end else begin
                e = exp_q[0];
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_rd", 64'(out_rd), 64'(e.rd));
                check("out_fflags", 64'(out_fflags), 64'(e.ff));
            end
            if (!reset_n || flush) begin
                exp_q.delete();
            end else begin
                if (sz != 0 && out_ready) begin
                    void'(exp_q.pop_front());
                end
                if (in_valid && sz < DEPTH && !(in_rd == 5'd0 && in_fflags == 5'd0)) begin
                    e.data = in_data;
                    e.rd   = in_rd;
                    e.ff   = in_fflags;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [XLEN-1:0] d, input logic [4:0] rd,
                       input logic [4:0] ff, input logic ordy,
                       input logic fl = 1'b0, input logic rn = 1'b1);
        in_valid  = v;
        in_data   = d;
        in_rd     = rd;
        in_fflags = ff;
        out_ready = ordy;
        flush     = fl;
        reset_n   = rn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        in_rd = '0; in_fflags = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Basic in-order path
        cyc(1, 32'h40, 5'd5, 5'd0, 1);
        cyc(1, 32'h200, 5'd6, 5'd0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // Fill and backpressure, 5th push refused
        for (int i = 0; i < 5; i++) cyc(1, 32'h100 + i, 5'd10 + 5'(i), 5'd0, 0);
        // Full with simultaneous pop: only the pop happens
        cyc(1, 32'hDEAD, 5'd7, 5'd1, 1);
        cyc(0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0, 1);

        // Pointer wrap with interleaved pops
        for (int i = 0; i < 10; i++) cyc(1, 32'(i), 5'd3, 5'd0, (i >= 2));
        repeat (4) cyc(0, 0, 0, 0, 1);

        // x0 handling
        cyc(1, 32'hAA, 5'd0, 5'd0, 0);
        cyc(1, 32'hBB, 5'd0, 5'b10000, 0);
        repeat (3) cyc(0, 0, 0, 0, 1);

        // Flush with push
        for (int i = 0; i < 3; i++) cyc(1, 32'h300 + i, 5'd9, 5'd0, 0);
        cyc(1, 32'h3FF, 5'd9, 5'd2, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 1);

        // Reset with push
        for (int i = 0; i < 3; i++) cyc(1, 32'h400 + i, 5'd11, 5'd0, 0);
        cyc(1, 32'h4FF, 5'd11, 5'd4, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 3) != 0),
                $urandom(),
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom()),
                ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom()),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 79) != 0));
        end
        repeat (DEPTH + 2) cyc(0, 0, 0, 0, 1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_int_wb_queue.md
Name: fp_int_wb_queue

Overview:
- Small FIFO between the FPU's integer-result producers (FCLASS, FEQ/FLT/FLE, FCVT.W[U], FMV.X.W) and the integer register file writeback port.
- Accepts one XLEN result per cycle on a valid/ready handshake, along with its destination register and exception flags.
- Presents results in order to integer writeback through a registered valid/ready output.
- Decouples the single-cycle FP integer-result units from integer writeback port arbitration stalls.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- XLEN, 32, integer result width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous discard of all entries (pipeline flush/trap).
- in_valid  input  1  producer presents a result.
- in_ready  output  1  queue can accept a result this cycle.
- in_data  input  XLEN  result value, e.g. a zero-extended 10-bit FCLASS mask.
- in_rd  input  5  integer destination register.
- in_fflags  input  5  NV/DZ/OF/UF/NX flags raised by the producing instruction.
- out_valid  output  1  head entry is available.
- out_ready  input  1  integer writeback consumes the head this cycle.
- out_data  output  XLEN  head result.
- out_rd  output  5  head destination register.
- out_fflags  output  5  head flags, committed to fcsr by the consumer on pop.
- count  output  $clog2(DEPTH)+1  number of stored entries.

Behaviour:
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- Storage: circular buffer with wrap-around read and write pointers and a separate occupancy counter. Full is count==DEPTH; empty is count==0.
- in_ready = !full. It is combinational from state only and does not depend on out_ready, so a full queue does not accept a push even when a pop happens in the same cycle.
- out_valid = !empty. out_data, out_rd and out_fflags are read from the head entry and are 0 when empty.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 at the earliest. There is no same-cycle bypass.
- rd==x0 entry with in_fflags==0: the handshake completes (in_ready honoured), the entry is discarded and count is unchanged.
- rd==x0 entry with nonzero fflags: stored normally so the flags still reach fcsr. The consumer suppresses the register write.
- Simultaneous push and pop on a non-full, non-empty queue: count is unchanged and both pointers advance.
- Simultaneous push and pop on an empty queue: the pop cannot occur (out_valid=0). The push is stored and count becomes 1.
- Pointers wrap from DEPTH-1 to 0. Ordering is strictly FIFO across the wrap.
- out_* hold stable while out_valid && !out_ready.
- in_data is stored unmodified. No width or sign manipulation.
- flush=1: next cycle count=0, both pointers 0, out_valid=0. Any same-cycle push or pop is ignored; flush has priority over both.
- Reset (reset_n=0 at a clock edge): identical to flush. Reset takes priority over flush and handshakes. Storage contents need not be cleared, but out_data, out_rd and out_fflags read 0 because they are gated by empty.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_rd=0, out_fflags=0, count=0.
- Reset or flush mid-operation drops all queued entries. No partial entry survives.

Test Plan:
- Basic in-order path: push {data=0x00000040, rd=5, fflags=0} then {0x00000200, rd=6, 0} with out_ready=1. Required: out_valid rises the cycle after the first push, out_data=0x40/rd=5 then 0x200/rd=6, count returns to 0.
- Fill and backpressure: out_ready=0, push DEPTH=4 entries. Required: count=4 and in_ready=0. A 5th in_valid is not accepted.
- Full with simultaneous pop: assert in_valid and out_ready together while full. Required: only the pop occurs, count=3, in_ready=1 the next cycle.
- Pointer wrap: 10 pushes of data=0..9 interleaved with pops, never exceeding 3 entries. Required: pops return 0..9 in order.
- x0 handling: push rd=0 with fflags=0, then rd=0 with fflags=5'b10000 (NV). Required: the first is accepted but not stored (count stays 0); the second is stored and popped with out_fflags=0x10, out_rd=0.
- Flush and reset: with 3 entries queued, assert flush together with in_valid. Required: count=0 and out_valid=0 next cycle, and the pushed entry is dropped. Repeat with reset_n=0. Required: all outputs at reset values and in_ready=1.
